// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the Arkanoid game-flow controller: state encoding,
// text-region bit positions and default timing/ball parameters.
package game_state_ctrl_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam int TXT_SCORE = 3;
  localparam int TXT_TITLE = 2;
  localparam int TXT_RULE  = 1;
  localparam int TXT_OVER  = 0;

  localparam int BALLS_INIT_DEF = 3;
  localparam int HOLD_TICKS_DEF = 120;

  // Overlay regions shown in each state; the score is visible everywhere.
  function automatic logic [3:0] text_mask(input state_t s);
    logic [3:0] m;
    m = '0;
    m[TXT_SCORE] = 1'b1;
    m[TXT_TITLE] = (s == NEWGAME);
    m[TXT_RULE]  = (s == NEWGAME);
    m[TXT_OVER]  = (s == OVER);
    return m;
  endfunction

endpackage

// File: rtl/game_state_ctrl_bcd_counter2.sv
// Two-digit BCD score counter: increments on inc, clears on clr,
// and saturates at 99.
module bcd_counter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] one_digit,
  output logic [3:0] ten_digit
);

  logic at_max;

  assign at_max = (ten_digit == 4'd9) && (one_digit == 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      one_digit <= 4'd0;
      ten_digit <= 4'd0;
    end else if (clr) begin
      one_digit <= 4'd0;
      ten_digit <= 4'd0;
    end else if (inc && !at_max) begin
      if (one_digit == 4'd9) begin
        one_digit <= 4'd0;
        ten_digit <= ten_digit + 4'd1;
      end else begin
        one_digit <= one_digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Arkanoid game-flow controller: game state machine, ball count, hold timer,
// button edge detect and registered overlay/freeze controls.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int BALLS_INIT = BALLS_INIT_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic [1:0] ball,
  output logic [3:0] one_digit,
  output logic [3:0] ten_digit,
  output logic [3:0] text_en,
  output logic       graph_still,
  output logic       game_over
);

  localparam logic [1:0] BALL_RST = 2'(BALLS_INIT);
  localparam logic [7:0] HOLD_VAL = 8'(HOLD_TICKS);

  state_t     state, state_nxt;
  logic [1:0] ball_nxt;
  logic [7:0] timer, timer_nxt;
  logic       btn_q, press;
  logic       score_inc, score_clr;

  // Rising edge only, so a held button cannot chain several transitions.
  assign press = (|btn) & ~btn_q;

  always_comb begin
    state_nxt = state;
    ball_nxt  = ball;
    timer_nxt = timer;
    score_inc = 1'b0;
    score_clr = 1'b0;
    case (state)
      NEWGAME: begin
        timer_nxt = 8'd0;
        if (press) state_nxt = PLAY;
      end
      PLAY: begin
        timer_nxt = 8'd0;
        score_inc = hit;
        if (miss) begin
          if (ball > 2'd1) begin
            ball_nxt  = ball - 2'd1;
            state_nxt = NEWBALL;
          end else begin
            ball_nxt  = 2'd0;
            state_nxt = OVER;
          end
        end
      end
      NEWBALL: begin
        if (press && timer == HOLD_VAL) begin
          state_nxt = PLAY;
          timer_nxt = 8'd0;
        end else if (refr_tick && timer < HOLD_VAL) begin
          timer_nxt = timer + 8'd1;
        end
      end
      OVER: begin
        // The tick that would reach the hold count ends the game instead.
        if (refr_tick) begin
          if ({1'b0, timer} + 9'd1 >= {1'b0, HOLD_VAL}) begin
            state_nxt = NEWGAME;
            timer_nxt = 8'd0;
            ball_nxt  = BALL_RST;
            score_clr = 1'b1;
          end else begin
            timer_nxt = timer + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= NEWGAME;
      ball        <= BALL_RST;
      timer       <= 8'd0;
      btn_q       <= 1'b0;
      text_en     <= 4'b1110;
      graph_still <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ball        <= ball_nxt;
      timer       <= timer_nxt;
      btn_q       <= |btn;
      text_en     <= text_mask(state_nxt);
      graph_still <= (state_nxt != PLAY);
      game_over   <= (state_nxt == OVER);
    end
  end

  bcd_counter2 u_score (
    .clk       (clk),
    .reset     (reset),
    .inc       (score_inc),
    .clr       (score_clr),
    .one_digit (one_digit),
    .ten_digit (ten_digit)
  );

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: a game-rule model checked on every
// falling edge, plus literal expectations at key points of a directed game.
module tb_game_state_ctrl;

  localparam int BALLS = 3;
  localparam int HOLD  = 120;

  localparam int MODE_TITLE = 0;
  localparam int MODE_PLAY  = 1;
  localparam int MODE_WAIT  = 2;
  localparam int MODE_END   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       refr_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [1:0] ball;
  logic [3:0] one_digit;
  logic [3:0] ten_digit;
  logic [3:0] text_en;
  logic       graph_still;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  int m_mode  = MODE_TITLE;
  int m_score = 0;
  int m_ball  = BALLS;
  int m_timer = 0;
  bit m_btn_prev = 1'b0;

  game_state_ctrl #(.BALLS_INIT(BALLS), .HOLD_TICKS(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .refr_tick   (refr_tick),
    .btn         (btn),
    .hit         (hit),
    .miss        (miss),
    .ball        (ball),
    .one_digit   (one_digit),
    .ten_digit   (ten_digit),
    .text_en     (text_en),
    .graph_still (graph_still),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic logic [7:0] exp_text(input int mode);
    case (mode)
      MODE_TITLE: return 8'd14;
      MODE_END:   return 8'd9;
      default:    return 8'd8;
    endcase
  endfunction

  // Game rules applied to whatever inputs were present at each rising edge.
  always @(posedge clk or posedge reset) begin
    bit pr;
    if (reset) begin
      m_mode = MODE_TITLE; m_score = 0; m_ball = BALLS; m_timer = 0; m_btn_prev = 1'b0;
    end else begin
      pr = (btn != 2'b00) && !m_btn_prev;
      m_btn_prev = (btn != 2'b00);
      case (m_mode)
        MODE_TITLE: if (pr) m_mode = MODE_PLAY;
        MODE_PLAY: begin
          if (hit && m_score < 99) m_score = m_score + 1;
          if (miss) begin
            m_ball = m_ball - 1;
            m_timer = 0;
            m_mode = (m_ball == 0) ? MODE_END : MODE_WAIT;
          end
        end
        MODE_WAIT: begin
          if (pr && m_timer == HOLD) begin
            m_mode = MODE_PLAY; m_timer = 0;
          end else if (refr_tick && m_timer < HOLD) begin
            m_timer = m_timer + 1;
          end
        end
        default: begin
          if (refr_tick) begin
            m_timer = m_timer + 1;
            if (m_timer >= HOLD) begin
              m_mode = MODE_TITLE; m_timer = 0; m_score = 0; m_ball = BALLS;
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check_output("ball", 8'(ball), 8'(m_ball));
    check_output("one_digit", 8'(one_digit), 8'(m_score % 10));
    check_output("ten_digit", 8'(ten_digit), 8'(m_score / 10));
    check_output("text_en", 8'(text_en), exp_text(m_mode));
    check_output("graph_still", 8'(graph_still), 8'(m_mode != MODE_PLAY));
    check_output("game_over", 8'(game_over), 8'(m_mode == MODE_END));
  end

  task automatic apply_stimulus(input logic [1:0] b, input logic h, input logic m, input logic r);
    btn = b; hit = h; miss = m; refr_tick = r;
    @(posedge clk);
    #1;
    hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(2'b00, 1'b0, 1'b0, 1'b1);
      apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_release();
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ball", 8'(ball), 8'd3);
    check_output("rst_text", 8'(text_en), 8'd14);
    check_output("rst_still", 8'(graph_still), 8'd1);
    check_output("rst_over", 8'(game_over), 8'd0);
    reset = 1'b0;
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0);

    // Held button: one transition only; refr ticks in the title are ignored.
    ticks(2);
    apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0);
    check_output("start_text", 8'(text_en), 8'd8);
    check_output("start_still", 8'(graph_still), 8'd0);
    for (int i = 0; i < 9; i++) apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0);
    check_output("held_still", 8'(graph_still), 8'd0);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0);

    hits(12);
    check_output("score12_ten", 8'(ten_digit), 8'd1);
    check_output("score12_one", 8'(one_digit), 8'd2);
    hits(25);
    ticks(3);
    apply_stimulus(2'b00, 1'b0, 1'b1, 1'b0);
    check_output("nb_ball", 8'(ball), 8'd2);
    check_output("nb_still", 8'(graph_still), 8'd1);
    hits(2);

    ticks(50);
    apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0);
    check_output("early_press_still", 8'(graph_still), 8'd1);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0);
    ticks(70);
    press_release();
    check_output("late_press_still", 8'(graph_still), 8'd0);
    check_output("score37_ten", 8'(ten_digit), 8'd3);
    check_output("score37_one", 8'(one_digit), 8'd7);

    // Mid-play reset with a hit pending must clear immediately.
    hit = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_output("midrst_ball", 8'(ball), 8'd3);
    check_output("midrst_one", 8'(one_digit), 8'd0);
    check_output("midrst_ten", 8'(ten_digit), 8'd0);
    check_output("midrst_text", 8'(text_en), 8'd14);
    check_output("midrst_still", 8'(graph_still), 8'd1);
    repeat (2) @(posedge clk);
    #1;
    hit = 1'b0;
    reset = 1'b0;
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0);

    press_release();
    apply_stimulus(2'b00, 1'b0, 1'b1, 1'b0);
    ticks(HOLD);
    press_release();
    hits(9);
    apply_stimulus(2'b00, 1'b1, 1'b1, 1'b0);
    check_output("both_ten", 8'(ten_digit), 8'd1);
    check_output("both_one", 8'(one_digit), 8'd0);
    check_output("both_ball", 8'(ball), 8'd1);
    check_output("both_still", 8'(graph_still), 8'd1);

    ticks(HOLD);
    press_release();
    hits(88);
    check_output("score98_one", 8'(one_digit), 8'd8);
    hits(3);
    check_output("score99_ten", 8'(ten_digit), 8'd9);
    check_output("score99_one", 8'(one_digit), 8'd9);

    apply_stimulus(2'b00, 1'b0, 1'b1, 1'b0);
    check_output("over_ball", 8'(ball), 8'd0);
    check_output("over_flag", 8'(game_over), 8'd1);
    check_output("over_text", 8'(text_en), 8'd9);
    check_output("over_score", 8'(ten_digit), 8'd9);
    apply_stimulus(2'b00, 1'b1, 1'b1, 1'b0);
    press_release();
    ticks(HOLD - 1);
    check_output("over_hold", 8'(game_over), 8'd1);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b1);
    check_output("ng_over", 8'(game_over), 8'd0);
    check_output("ng_text", 8'(text_en), 8'd14);
    check_output("ng_one", 8'(one_digit), 8'd0);
    check_output("ng_ten", 8'(ten_digit), 8'd0);
    check_output("ng_ball", 8'(ball), 8'd3);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
